vga_chargen: RTL and testbench

VGA_CHARGEN -- requirements
Module: vga_chargen

---
 rtl/vga_chargen_if.sv | 45 ++++
 rtl/vga_chargen.sv | 177 +++++++++++++++++
 tb/tb_vga_chargen.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_chargen_if.sv
// Shared font widths and the host-side RAM port bundle (char map, colour map, font).
// Signal suffixes are from the display core's point of view.
package vga_chargen_pkg;
  localparam int CH_T_ADDR_WIDTH = 8;
  localparam int CH_T_DATA_WIDTH = 128;
endpackage

interface vga_chargen_if;
  import vga_chargen_pkg::*;

  logic [9:0]                 char_map_addr_i;
  logic                       char_map_we_i;
  logic [3:0]                 char_map_be_i;
  logic [31:0]                char_map_wdata_i;
  logic [31:0]                char_map_rdata_o;

  logic [9:0]                 col_map_addr_i;
  logic                       col_map_we_i;
  logic [3:0]                 col_map_be_i;
  logic [31:0]                col_map_wdata_i;
  logic [31:0]                col_map_rdata_o;

  logic [CH_T_ADDR_WIDTH-1:0] char_tiff_addr_i;
  logic                       char_tiff_we_i;
  logic [CH_T_DATA_WIDTH-1:0] char_tiff_wdata_i;
  logic [CH_T_DATA_WIDTH-1:0] char_tiff_rdata_o;

  modport master (
    output char_map_addr_i, char_map_we_i, char_map_be_i, char_map_wdata_i,
    input  char_map_rdata_o,
    output col_map_addr_i, col_map_we_i, col_map_be_i, col_map_wdata_i,
    input  col_map_rdata_o,
    output char_tiff_addr_i, char_tiff_we_i, char_tiff_wdata_i,
    input  char_tiff_rdata_o
  );

  modport slave (
    input  char_map_addr_i, char_map_we_i, char_map_be_i, char_map_wdata_i,
    output char_map_rdata_o,
    input  col_map_addr_i, col_map_we_i, col_map_be_i, col_map_wdata_i,
    output col_map_rdata_o,
    input  char_tiff_addr_i, char_tiff_we_i, char_tiff_wdata_i,
    output char_tiff_rdata_o
  );
endinterface

// File: rtl/vga_chargen.sv
// 80x30 text-mode VGA generator (640x480, 8x16 glyphs) with host-writable char/colour/font RAMs.
// RGB and syncs leave a 3-pixel-period registered pipeline together; host ports never stall display.
module vga_chargen
  import vga_chargen_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  vga_chargen_if.slave bus,
  output logic [3:0]   vga_r_o,
  output logic [3:0]   vga_g_o,
  output logic [3:0]   vga_b_o,
  output logic         vga_hs_o,
  output logic         vga_vs_o
);

  localparam int         MAP_WORDS = 600;
  localparam int         DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [9:0] MAP_LAST  = 10'd599;

  function automatic logic [11:0] palette(input logic [3:0] idx);
    logic [3:0] on_v, off_v;
    on_v  = idx[3] ? 4'hF : 4'hA;
    off_v = idx[3] ? 4'h5 : 4'h0;
    return {idx[2] ? on_v : off_v, idx[1] ? on_v : off_v, idx[0] ? on_v : off_v};
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en;
  logic [9:0]       h_q, h_d, v_q, v_d;

  always_comb begin
    pix_en = (div_q == DIV_W'(CLK_DIV - 1));
    div_d  = pix_en ? '0 : div_q + DIV_W'(1);
    h_d    = h_q;
    v_d    = v_q;
    if (pix_en) begin
      if (h_q == 10'd799) begin
        h_d = '0;
        v_d = (v_q == 10'd524) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  logic        vis0, hs0, vs0;
  logic [11:0] cell0;

  always_comb begin
    vis0  = (h_q < 10'd640) && (v_q < 10'd480);
    hs0   = !((h_q >= 10'd656) && (h_q < 10'd752));
    vs0   = !((v_q >= 10'd490) && (v_q < 10'd492));
    cell0 = vis0 ? (12'(v_q[8:4]) * 12'd80 + 12'(h_q[9:3])) : '0;
  end

  logic [31:0]                char_mem [MAP_WORDS];
  logic [31:0]                col_mem  [MAP_WORDS];
  logic [CH_T_DATA_WIDTH-1:0] font_mem [2**CH_T_ADDR_WIDTH];

  logic char_wr, col_wr, font_wr;
  assign char_wr = !rst_i && bus.char_map_we_i && (bus.char_map_addr_i <= MAP_LAST);
  assign col_wr  = !rst_i && bus.col_map_we_i  && (bus.col_map_addr_i  <= MAP_LAST);
  assign font_wr = !rst_i && bus.char_tiff_we_i;

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (char_wr && bus.char_map_be_i[k])
        char_mem[bus.char_map_addr_i][8*k +: 8] <= bus.char_map_wdata_i[8*k +: 8];
      if (col_wr && bus.col_map_be_i[k])
        col_mem[bus.col_map_addr_i][8*k +: 8] <= bus.col_map_wdata_i[8*k +: 8];
    end
    if (font_wr)
      font_mem[bus.char_tiff_addr_i] <= bus.char_tiff_wdata_i;
  end

  logic [31:0]                char_rdata_q, col_rdata_q;
  logic [CH_T_DATA_WIDTH-1:0] font_rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      char_rdata_q <= '0;
      col_rdata_q  <= '0;
      font_rdata_q <= '0;
    end else begin
      char_rdata_q <= (bus.char_map_addr_i <= MAP_LAST) ? char_mem[bus.char_map_addr_i] : '0;
      col_rdata_q  <= (bus.col_map_addr_i  <= MAP_LAST) ? col_mem[bus.col_map_addr_i]   : '0;
      font_rdata_q <= font_mem[bus.char_tiff_addr_i];
    end
  end

  assign bus.char_map_rdata_o  = char_rdata_q;
  assign bus.col_map_rdata_o   = col_rdata_q;
  assign bus.char_tiff_rdata_o = font_rdata_q;

  // Display-side reads are separate ports; a same-edge host write is seen next fetch.
  logic [31:0]                chr_word_q, col_word_q;
  logic [CH_T_DATA_WIDTH-1:0] glyph_q;
  logic [1:0]                 lane1_q;
  logic [7:0]                 chr_code;

  assign chr_code = chr_word_q[{lane1_q, 3'b000} +: 8];

  always_ff @(posedge clk_i) begin
    if (pix_en) begin
      chr_word_q <= char_mem[cell0[11:2]];
      col_word_q <= col_mem[cell0[11:2]];
      glyph_q    <= font_mem[chr_code];
    end
  end

  logic [2:0]  x1_q, x2_q;
  logic [3:0]  y1_q, y2_q;
  logic        vis1_q, vis2_q, hs1_q, hs2_q, vs1_q, vs2_q;
  logic [7:0]  colb2_q;
  logic [11:0] rgb_q;
  logic        hs_q, vs_q;
  logic        pix_bit;

  assign pix_bit = glyph_q[{y2_q, x2_q}];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane1_q <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      colb2_q <= '0;
      vis1_q  <= 1'b0;
      vis2_q  <= 1'b0;
      hs1_q   <= 1'b1;
      hs2_q   <= 1'b1;
      vs1_q   <= 1'b1;
      vs2_q   <= 1'b1;
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else if (pix_en) begin
      lane1_q <= cell0[1:0];
      x1_q    <= h_q[2:0];
      y1_q    <= v_q[3:0];
      vis1_q  <= vis0;
      hs1_q   <= hs0;
      vs1_q   <= vs0;
      colb2_q <= col_word_q[{lane1_q, 3'b000} +: 8];
      x2_q    <= x1_q;
      y2_q    <= y1_q;
      vis2_q  <= vis1_q;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      rgb_q   <= vis2_q ? palette(pix_bit ? colb2_q[7:4] : colb2_q[3:0]) : '0;
      hs_q    <= hs2_q;
      vs_q    <= vs2_q;
    end
  end

  assign vga_r_o  = rgb_q[11:8];
  assign vga_g_o  = rgb_q[7:4];
  assign vga_b_o  = rgb_q[3:0];
  assign vga_hs_o = hs_q;
  assign vga_vs_o = vs_q;

endmodule

// File: tb/tb_vga_chargen.sv
// Directed bench for vga_chargen: RAM port readback, byte enables, reset rules, sync timing, pixels.
module tb_vga_chargen;
  localparam int D = 2;
  localparam logic [11:0] PAL [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hAA0, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] r, g, b;
  logic       hs, vs;

  always #5 clk = ~clk;

  vga_chargen_if bus ();

  vga_chargen #(.CLK_DIV(D)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .vga_r_o (r),
    .vga_g_o (g),
    .vga_b_o (b),
    .vga_hs_o(hs),
    .vga_vs_o(vs)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]  char_m [600];
  logic [31:0]  col_m  [600];
  logic [127:0] font_m [256];
  logic [11:0]  pix_log [1900];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.char_map_we_i  = 1'b0;
    bus.col_map_we_i   = 1'b0;
    bus.char_tiff_we_i = 1'b0;
  endtask

  task automatic map_wr(input bit sel_col, input int a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.char_tiff_we_i = 1'b0;
    if (sel_col) begin
      bus.char_map_we_i = 1'b0;
      bus.col_map_addr_i = 10'(a); bus.col_map_we_i = 1'b1;
      bus.col_map_be_i = be;       bus.col_map_wdata_i = d;
    end else begin
      bus.col_map_we_i = 1'b0;
      bus.char_map_addr_i = 10'(a); bus.char_map_we_i = 1'b1;
      bus.char_map_be_i = be;       bus.char_map_wdata_i = d;
    end
    if (!rst && a < 600)
      for (int k = 0; k < 4; k++)
        if (be[k]) begin
          if (sel_col) col_m[a][8*k +: 8] = d[8*k +: 8];
          else         char_m[a][8*k +: 8] = d[8*k +: 8];
        end
  endtask

  task automatic font_wr(input int a, input logic [127:0] d);
    @(negedge clk);
    bus.char_map_we_i = 1'b0;
    bus.col_map_we_i  = 1'b0;
    bus.char_tiff_addr_i = 8'(a); bus.char_tiff_we_i = 1'b1; bus.char_tiff_wdata_i = d;
    if (!rst) font_m[a] = d;
  endtask

  task automatic rd_map(input bit sel_col, input int a, output logic [31:0] d);
    @(negedge clk);
    if (sel_col) bus.col_map_addr_i = 10'(a); else bus.char_map_addr_i = 10'(a);
    @(negedge clk);
    d = sel_col ? bus.col_map_rdata_o : bus.char_map_rdata_o;
  endtask

  function automatic logic [11:0] exp_pix(input int h, input int v);
    int n;
    logic [7:0] cb, co;
    logic [127:0] gl;
    if (h >= 640 || v >= 480) return 12'h000;
    n  = (v / 16) * 80 + h / 8;
    cb = char_m[n / 4][8 * (n % 4) +: 8];
    co = col_m[n / 4][8 * (n % 4) +: 8];
    gl = font_m[cb];
    return gl[(v % 16) * 8 + h % 8] ? PAL[co[7:4]] : PAL[co[3:0]];
  endfunction

  // Called right after rst is dropped at a negedge; pixel p appears after posedge (p+3)*D.
  task automatic scan(input int npix, input string tag);
    int p, h, v, bad_rgb, bad_sync, blank_nz, hs_low0, hs_low1;
    logic [11:0] got;
    bad_rgb = 0; bad_sync = 0; blank_nz = 0; hs_low0 = 0; hs_low1 = 0;
    for (int c = 1; c <= (npix + 2) * D; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c % D == 0 && c >= 3 * D) begin
        p = c / D - 3;
        h = p % 800;
        v = p / 800;
        got = {r, g, b};
        pix_log[p] = got;
        if (got !== exp_pix(h, v)) bad_rgb++;
        if (h >= 640 && got !== 12'h000) blank_nz++;
        if (hs !== !(h >= 656 && h < 752) || vs !== !(v >= 490 && v < 492)) bad_sync++;
        if (v == 0 && hs === 1'b0) hs_low0++;
        if (v == 1 && hs === 1'b0) hs_low1++;
      end
    end
    check_eq({tag, "_rgb_vs_model"}, 128'(bad_rgb), 128'(0));
    check_eq({tag, "_sync_errs"}, 128'(bad_sync), 128'(0));
    check_eq({tag, "_blank_rgb"}, 128'(blank_nz), 128'(0));
    check_eq({tag, "_hs_low_line0"}, 128'(hs_low0), 128'(96));
    if (npix >= 1600) check_eq({tag, "_hs_low_line1"}, 128'(hs_low1), 128'(96));
  endtask

  logic [31:0] ev, rd;

  initial begin
    rst = 1'b1;
    bus.char_map_addr_i = '0; bus.char_map_we_i = 1'b0; bus.char_map_be_i = '0; bus.char_map_wdata_i = '0;
    bus.col_map_addr_i  = '0; bus.col_map_we_i  = 1'b0; bus.col_map_be_i  = '0; bus.col_map_wdata_i  = '0;
    bus.char_tiff_addr_i = '0; bus.char_tiff_we_i = 1'b0; bus.char_tiff_wdata_i = '0;
    repeat (4) @(negedge clk);
    check_eq("rst_rgb", 128'({r, g, b}), 128'(0));
    check_eq("rst_hs", 128'(hs), 128'(1));
    check_eq("rst_vs", 128'(vs), 128'(1));
    check_eq("rst_char_rdata", 128'(bus.char_map_rdata_o), 128'(0));
    check_eq("rst_col_rdata", 128'(bus.col_map_rdata_o), 128'(0));
    check_eq("rst_font_rdata", bus.char_tiff_rdata_o, 128'(0));
    rst = 1'b0;

    for (int a = 0; a < 600; a++) begin
      ev = 32'(a);
      map_wr(1'b1, a, {4{ev[7:0]}}, 4'hF);
    end
    idle();
    for (int a = 0; a <= 600; a++) begin
      @(negedge clk);
      if (a > 0) begin
        ev = 32'(a - 1);
        check_eq("colmap_rd", 128'(bus.col_map_rdata_o), 128'({4{ev[7:0]}}));
      end
      if (a < 600) bus.col_map_addr_i = 10'(a);
    end

    for (int a = 0; a < 600; a++) map_wr(1'b0, a, 32'(a), 4'hF);
    idle();
    for (int a = 0; a <= 599; a++) begin
      @(negedge clk);
      if (a > 0) check_eq("charmap_rd", 128'(bus.char_map_rdata_o), 128'(a - 1));
      if (a < 599) bus.char_map_addr_i = 10'(a);
    end

    for (int a = 0; a < 256; a++) font_wr(a, 128'(a));
    idle();
    for (int a = 0; a <= 256; a++) begin
      @(negedge clk);
      if (a > 0) check_eq("font_rd", bus.char_tiff_rdata_o, 128'(a - 1));
      if (a < 256) bus.char_tiff_addr_i = 8'(a);
    end

    map_wr(1'b0, 599, 32'hFFFF_FFFF, 4'hF);
    map_wr(1'b0, 599, 32'h0000_0000, 4'b0101);
    idle();
    rd_map(1'b0, 599, rd);
    check_eq("byte_enable", 128'(rd), 128'(32'hFF00_FF00));

    map_wr(1'b0, 700, 32'h1234_5678, 4'hF);
    idle();
    rd_map(1'b0, 700, rd);
    check_eq("oor_char_rd", 128'(rd), 128'(0));
    rd_map(1'b1, 1023, rd);
    check_eq("oor_col_rd", 128'(rd), 128'(0));
    rd_map(1'b0, 188, rd);
    check_eq("oor_no_alias", 128'(rd), 128'(188));

    @(negedge clk);
    rst = 1'b1;
    map_wr(1'b0, 10, 32'hDEAD_BEEF, 4'hF);
    idle();
    @(negedge clk);
    check_eq("rst_rdata_hold0", 128'(bus.char_map_rdata_o), 128'(0));
    rst = 1'b0;
    rd_map(1'b0, 10, rd);
    check_eq("rst_write_ignored", 128'(rd), 128'(10));

    map_wr(1'b0, 0, 32'h0000_0041, 4'b0001);
    map_wr(1'b1, 0, 32'h0000_00F1, 4'b0001);
    font_wr(8'h41, 128'h8001);
    idle();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    scan(1900, "scan1");
    check_eq("pix_0_0", 128'(pix_log[0]), 128'(12'hFFF));
    check_eq("pix_1_0", 128'(pix_log[1]), 128'(12'h00A));
    check_eq("pix_8_0", 128'(pix_log[8]), 128'(12'h000));
    check_eq("pix_7_1", 128'(pix_log[807]), 128'(12'hFFF));
    check_eq("pix_608_0", 128'(pix_log[608]), 128'(12'h00A));
    check_eq("pix_610_0", 128'(pix_log[610]), 128'(12'h0AA));
    check_eq("pix_700_0", 128'(pix_log[700]), 128'(12'h000));

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midrst_rgb", 128'({r, g, b}), 128'(0));
    check_eq("midrst_hs", 128'(hs), 128'(1));
    check_eq("midrst_vs", 128'(vs), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) pix_log[i] = 12'hBAD;
    scan(800, "scan2");
    check_eq("restart_pix_0_0", 128'(pix_log[0]), 128'(12'hFFF));
    check_eq("restart_pix_1_0", 128'(pix_log[1]), 128'(12'h00A));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
